// File: rtl/alu_pkg.sv
// Shared ALU/MD encodings: ALU op codes, R-type function codes and MD FSM states.
package alu_pkg;

    localparam int ALUCTRL_WIRENUM = 5;

    localparam logic [ALUCTRL_WIRENUM-1:0] OP_NOP  = 5'd0;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_ADD  = 5'd1;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_ADDU = 5'd2;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SUB  = 5'd3;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SUBU = 5'd4;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_AND  = 5'd5;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_OR   = 5'd6;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_XOR  = 5'd7;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_NOR  = 5'd8;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SLT  = 5'd9;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SLTU = 5'd10;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SLL  = 5'd11;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SRL  = 5'd12;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SRA  = 5'd13;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SLLV = 5'd14;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SRLV = 5'd15;
    localparam logic [ALUCTRL_WIRENUM-1:0] OP_SRAV = 5'd16;

    localparam logic [5:0] FUNC_SLL   = 6'h00;
    localparam logic [5:0] FUNC_SRL   = 6'h02;
    localparam logic [5:0] FUNC_SRA   = 6'h03;
    localparam logic [5:0] FUNC_SLLV  = 6'h04;
    localparam logic [5:0] FUNC_SRLV  = 6'h06;
    localparam logic [5:0] FUNC_SRAV  = 6'h07;
    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h22;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_XOR   = 6'h26;
    localparam logic [5:0] FUNC_NOR   = 6'h27;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

    typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

    // MULT/MULTU/DIV/DIVU occupy 6'h18..6'h1B
    function automatic logic is_md_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Radix-2 multiply (shift-add) / restoring divide iteration registers.
// ALU_MD_EARLY_OUT_EN adds a one-cycle multiply finish once remaining multiplier bits are zero.
module md_datapath
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_step,
    input  logic         i_is_div,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
`ifdef ALU_MD_EARLY_OUT_EN
    ,
    input  logic                    i_fin,
    input  logic [$clog2(W+1)-1:0]  i_cnt,
    output logic                    o_mul_zero
`endif
);

    logic [W-1:0] r_hi, r_lo, r_b;
    logic [W:0]   w_sum, w_trial;

    // r_lo holds the multiplier (mul) or the dividend shifting into the quotient (div)
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    assign w_trial = {r_hi, r_lo[W-1]} - {1'b0, r_b};

`ifdef ALU_MD_EARLY_OUT_EN
    logic [W-1:0] w_mask;
    assign w_mask     = ~({W{1'b1}} << i_cnt);
    assign o_mul_zero = ((r_lo & w_mask) == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
`ifdef ALU_MD_EARLY_OUT_EN
        end else if (i_fin) begin
            {r_hi, r_lo} <= {r_hi, r_lo} >> i_cnt;
`endif
        end else if (i_step) begin
            if (i_is_div) begin
                r_hi <= w_trial[W] ? {r_hi[W-2:0], r_lo[W-1]} : w_trial[W-1:0];
                r_lo <= {r_lo[W-2:0], ~w_trial[W]};
            end else begin
                {r_hi, r_lo} <= {w_sum, r_lo[W-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/alu_md_ctrl.sv
// ALU control decode plus iterative MULT/DIV unit owning HI/LO, with pipeline stall.
// Optional macro ALU_MD_EARLY_OUT_EN: multiplies may finish early.
//   state | meaning
//   IDLE  | no MD op in flight; accepts MD ops and MTHI/MTLO
//   RUN   | one radix-2 iteration per cycle
//   FIX   | sign correction, HI/LO write
module alu_md_ctrl
    import alu_pkg::*;
#(
    parameter  int W     = 32,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [5:0]                 funct,
    input  logic [1:0]                 ALUOp,
    input  logic                       issue,
    input  logic [W-1:0]               rs_val,
    input  logic [W-1:0]               rt_val,
    output logic [ALUCTRL_WIRENUM-1:0] ALUCTRL,
    output logic                       shift,
    output logic                       md_sel,
    output logic [W-1:0]               md_rdata,
    output logic                       busy,
    output logic                       stall,
    output logic [W-1:0]               hi,
    output logic [W-1:0]               lo
);

    md_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]   r_hi, r_lo;
    logic           r_is_div, r_neg_q, r_neg_r;
    logic           w_rtype, w_is_md, w_is_mf, w_is_mt, w_idle, w_accept, w_mt_wr, w_step;
    logic           w_signed, w_sa, w_sb, w_b_zero;
    logic [W-1:0]   w_a_mag, w_b_mag, w_dp_hi, w_dp_lo, w_quo_fix, w_rem_fix;
    logic [2*W-1:0] w_prod, w_prod_fix;
`ifdef ALU_MD_EARLY_OUT_EN
    logic           w_fin, w_mul_zero;
`endif

    assign w_rtype = ALUOp[1];

    always_comb begin
        ALUCTRL = OP_NOP;
        shift   = 1'b0;
        if (w_rtype) begin
            case (funct)
                FUNC_ADD:  ALUCTRL = OP_ADD;
                FUNC_ADDU: ALUCTRL = OP_ADDU;
                FUNC_SUB:  ALUCTRL = OP_SUB;
                FUNC_SUBU: ALUCTRL = OP_SUBU;
                FUNC_AND:  ALUCTRL = OP_AND;
                FUNC_OR:   ALUCTRL = OP_OR;
                FUNC_XOR:  ALUCTRL = OP_XOR;
                FUNC_NOR:  ALUCTRL = OP_NOR;
                FUNC_SLT:  ALUCTRL = OP_SLT;
                FUNC_SLTU: ALUCTRL = OP_SLTU;
                FUNC_SLL:  begin ALUCTRL = OP_SLL; shift = 1'b1; end
                FUNC_SRL:  begin ALUCTRL = OP_SRL; shift = 1'b1; end
                FUNC_SRA:  begin ALUCTRL = OP_SRA; shift = 1'b1; end
                FUNC_SLLV: ALUCTRL = OP_SLLV;
                FUNC_SRLV: ALUCTRL = OP_SRLV;
                FUNC_SRAV: ALUCTRL = OP_SRAV;
                default:   ALUCTRL = OP_NOP;
            endcase
        end else begin
            ALUCTRL = ALUOp[0] ? OP_SUB : OP_ADD;
        end
    end

    assign w_is_md  = is_md_funct(funct);
    assign w_is_mf  = (funct == FUNC_MFHI) || (funct == FUNC_MFLO);
    assign w_is_mt  = (funct == FUNC_MTHI) || (funct == FUNC_MTLO);
    assign w_idle   = (r_state == IDLE);
    assign w_accept = issue && w_rtype && w_is_md && w_idle;
    assign w_mt_wr  = issue && w_rtype && w_is_mt && w_idle;
    assign stall    = issue && w_rtype && (w_is_md || w_is_mf || w_is_mt) && !w_idle;
    assign busy     = !w_idle;
    assign md_sel   = w_rtype && w_is_mf;
    assign md_rdata = (funct == FUNC_MFHI) ? r_hi : r_lo;
    assign hi       = r_hi;
    assign lo       = r_lo;

    // Even funct codes are the signed variants
    assign w_signed = !funct[0];
    assign w_sa     = w_signed && rs_val[W-1];
    assign w_sb     = w_signed && rt_val[W-1];
    assign w_a_mag  = w_sa ? -rs_val : rs_val;
    assign w_b_mag  = w_sb ? -rt_val : rt_val;
    assign w_b_zero = (rt_val == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
`ifdef ALU_MD_EARLY_OUT_EN
        w_fin       = 1'b0;
`endif
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = RUN;
            RUN: begin
`ifdef ALU_MD_EARLY_OUT_EN
                if (!r_is_div && w_mul_zero) begin
                    w_fin       = 1'b1;
                    w_state_nxt = FIX;
                end else
`endif
                begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
                end
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Divide by zero leaves the unsigned quotient all ones and the remainder equal to |rs|,
    // so suppressing the quotient negate yields LO = all ones and HI = rs as issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= CNT_W'(W);
            r_is_div <= funct[1];
            r_neg_q  <= (w_sa ^ w_sb) && !(funct[1] && w_b_zero);
            r_neg_r  <= w_sa;
        end else if (w_step) begin
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    md_datapath #(.W(W)) u_md_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_is_div   (r_is_div),
        .i_a        (w_a_mag),
        .i_b        (w_b_mag),
        .o_hi       (w_dp_hi),
        .o_lo       (w_dp_lo)
`ifdef ALU_MD_EARLY_OUT_EN
        ,
        .i_fin      (w_fin),
        .i_cnt      (r_cnt),
        .o_mul_zero (w_mul_zero)
`endif
    );

    assign w_prod     = {w_dp_hi, w_dp_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -w_dp_lo : w_dp_lo;
    assign w_rem_fix  = r_neg_r ? -w_dp_hi : w_dp_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == FIX) begin
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else begin
                {r_hi, r_lo} <= w_prod_fix;
            end
        end else if (w_mt_wr) begin
            if (funct == FUNC_MTHI) r_hi <= rs_val;
            if (funct == FUNC_MTLO) r_lo <= rs_val;
        end
    end

endmodule

// File: doc/alu_md_ctrl.md
Name: alu_md_ctrl

Overview:
- Next-generation ALU control unit for the MIPS datapath: decodes `ALUOp`/`funct` into `ALUCTRL` and `shift`, and adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) that owns HI/LO.
- Serves MFHI/MFLO/MTHI/MTLO.
- Sits between the main control unit and the ALU/writeback mux in EX.
- Raises `stall` to the hazard unit while a multi-cycle op is in flight.

Parameters:
- `W`, 32, operand/HI/LO width; even, >= 8.
- `CNT_W`, `$clog2(W+1)`, iteration counter width (derived; not overridden).

Ports:
- `clk`  input  1  system clock
- `rst_n`  input  1  asynchronous active-low reset
- `funct`  input  6  R-type function field
- `ALUOp`  input  2  from main control; `2'b1x` = R-type, `00` = add, `01` = sub
- `issue`  input  1  instruction in EX is valid this cycle
- `rs_val`  input  W  operand A / dividend / MTHI-MTLO source
- `rt_val`  input  W  operand B / divisor
- `ALUCTRL`  output  `ALUCTRL_WIRENUM`  ALU operation code
- `shift`  output  1  1 = ALU B input takes shamt (SLL/SRL/SRA only)
- `md_sel`  output  1  1 = writeback takes `md_rdata` (MFHI/MFLO)
- `md_rdata`  output  W  HI (MFHI) or LO (MFLO)
- `busy`  output  1  multiply/divide in progress
- `stall`  output  1  hold EX and earlier stages this cycle
- `hi`, `lo`  output  W  architectural HI/LO

Behaviour:
- Decode is combinational.
  - R-type: ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV map to the matching `OP_*`.
  - JR, MD ops, MF/MT and unknown funct map to `OP_NOP`.
  - `ALUOp` 00 maps to `OP_ADD`, 01 to `OP_SUB`.
  - `shift` = 1 only for SLL/SRL/SRA; 0 for everything else, including the V-forms.
- Reset (async, `rst_n`=0): state IDLE, `hi`=`lo`=0, counter 0, `busy`=0. `stall` depends only on IDLE state, so it reads 0.
- FSM states: IDLE, RUN, FIX.
  - An MD op is accepted when `issue` & R-type & MD funct & IDLE.
  - On accept: latch operand magnitudes (signed ops take abs), result-sign flags and op type; load counter = W; go to RUN.
  - RUN: one radix-2 step per cycle; multiply is shift-add, divide is restoring. Counter decrements; at 1 go to FIX.
  - FIX: apply sign corrections, write `hi`/`lo`, go to IDLE.
- Timing: accept at cycle 0, `busy`=1 for cycles 1..W+1, new HI/LO visible from cycle W+2.
- Multiply: {HI,LO} = full 2W-bit product.
- Divide:
  - LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
  - Signed divide of most-negative by -1 gives LO = most-negative, HI = 0.
- Divide by zero (either signedness): completes with normal latency; LO = all ones, HI = `rs_val` as issued.
- MTHI/MTLO with `issue` in IDLE write `hi`/`lo` at the next edge.
- `stall` = `issue` & R-type & (MD/MF/MT funct) & !IDLE.
  - Stalled instructions are not accepted.
  - They are re-presented by the pipeline and accepted on the first cycle state is IDLE.
- MFHI/MFLO: `md_sel`=1 and `md_rdata` = current `hi`/`lo`, combinational.
- `issue`=0 suppresses all accepts and writes; decode outputs still reflect the inputs.
- Reset mid-op aborts immediately: HI/LO are cleared and the partial result is discarded.

Optional Feature:
- Macro: `ALU_MD_EARLY_OUT_EN`.
- Defined:
  - MULT/MULTU jump from RUN to FIX as soon as the remaining multiplier bits are all zero, with the product correctly shifted.
  - Latency is then variable, minimum 2 cycles of `busy`.
  - Divide is unchanged.
- Undefined: fixed W+1-cycle latency for all MD ops.

Decomposition:
- Shared `alu_pkg`: `OP_*` encodings and `ALUCTRL_WIRENUM`; `FUNC_*` codes, including new `FUNC_MULT`=`6'h18`, `FUNC_MULTU`=`6'h19`, `FUNC_DIV`=`6'h1A`, `FUNC_DIVU`=`6'h1B`, `FUNC_MFHI`=`6'h10`, `FUNC_MTHI`=`6'h11`, `FUNC_MFLO`=`6'h12`, `FUNC_MTLO`=`6'h13`; `md_state_t` enum.
- One sub-module, `md_datapath`: iteration registers and step logic, driven by the FSM in `alu_md_ctrl`.

Test Plan (W=32, early-out undefined):
- Decode sweep: every supported funct with `ALUOp`=10, then `ALUOp` 00/01 -> expected `OP_*`; `shift`=1 only for `6'h00`/`6'h02`/`6'h03`.
- MULT rs=7, rt=`32'hFFFFFFFD` -> `busy` for 33 cycles; HI=`32'hFFFFFFFF`, LO=`32'hFFFFFFEB`.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=`32'hFFFFFFFD`, HI=`32'hFFFFFFFF`. DIV `32'h80000000`/-1 -> LO=`32'h80000000`, HI=0.
- DIV 5/0 -> LO=`32'hFFFFFFFF`, HI=5, normal latency.
- MFLO issued at cycle 3 of a MULTU -> `stall`=1 through cycle 33; accepted at cycle 34 returning the new LO. MTHI `32'h1234` while IDLE -> `hi`=`32'h1234` next cycle.
- `rst_n` low at cycle 10 of a DIV -> `busy`=0, `hi`=`lo`=0 immediately; a following MULT 3*4 gives LO=12, HI=0.
